onchip_mem_arbiter: RTL and testbench

- Shares one single-port on-chip RAM between two Avalon-MM masters: m0 is the CPU data master and m1 is the DMA/peripheral master.
- RAM is 32-bit wide, 13-bit word address, 4-bit byteenable, unregistered output, 1-cycle read latency.
- Arbitration is round-robin, one access issued per cycle, with waitrequest back-pressure and a readdatavalid return.
- Built-in clear engine zeroes the whole RAM on request; sits between the system interconnect and the RAM wrapper.

---
 rtl/onchip_mem_pkg.sv | 16 +
 rtl/onchip_mem_arbiter_rr_arbiter2.sv | 36 +++
 rtl/onchip_mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_onchip_mem_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_mem_pkg.sv
// Shared sizes, FSM state type and master index type for the on-chip RAM arbiter.
package onchip_mem_pkg;

    localparam int unsigned ADDR_W    = 13;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned BE_W      = DATA_W / 8;
    localparam int unsigned NUM_WORDS = 5750;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    typedef logic master_t;

endpackage

// File: rtl/onchip_mem_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter: on a tie the master other than last_grant wins.
module rr_arbiter2
    import onchip_mem_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [1:0] req,
    output logic [1:0] grant,
    output master_t    last_grant
);

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = (last_grant == 1'b1) ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    // Reset to master 1 so that master 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
        end else if (grant[0]) begin
            last_grant <= 1'b0;
        end else if (grant[1]) begin
            last_grant <= 1'b1;
        end
    end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares one single-port RAM between two Avalon-MM masters, with a whole-RAM clear engine.
module onchip_mem_arbiter #(
    parameter int unsigned ADDR_W    = onchip_mem_pkg::ADDR_W,
    parameter int unsigned DATA_W    = onchip_mem_pkg::DATA_W,
    parameter int unsigned BE_W      = onchip_mem_pkg::BE_W,
    parameter int unsigned NUM_WORDS = onchip_mem_pkg::NUM_WORDS
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    input  logic              init_start,
    output logic              init_busy,
    output logic              init_done,

    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    import onchip_mem_pkg::*;

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              pend;
    master_t           pend_owner;
    logic              pend_oor;

    logic [1:0]        req;
    logic [1:0]        grant;
    logic              granted;
    logic              arb_en;
    master_t           last_grant;
    master_t           sel;
    logic [ADDR_W-1:0] sel_addr;
    logic [BE_W-1:0]   sel_be;
    logic [DATA_W-1:0] sel_wd;
    logic              sel_wr;
    logic              in_range;
    logic              rd_accept;

    assign req     = {m1_read | m1_write, m0_read | m0_write};
    assign arb_en  = (state == IDLE) && !init_start;
    assign granted = |grant;
    assign sel     = grant[1];

    rr_arbiter2 u_arb (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (arb_en),
        .req        (req),
        .grant      (grant),
        .last_grant (last_grant)
    );

    assign sel_addr  = sel ? m1_address    : m0_address;
    assign sel_be    = sel ? m1_byteenable : m0_byteenable;
    assign sel_wd    = sel ? m1_writedata  : m0_writedata;
    assign sel_wr    = sel ? m1_write      : m0_write;
    assign in_range  = 32'(sel_addr) < NUM_WORDS;
    // A simultaneous read+write is treated as a write only.
    assign rd_accept = granted && !sel_wr;

    // RAM port mux: clear engine owns the RAM while clearing, otherwise the granted master.
    always_comb begin
        mem_address    = '0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        if (state == CLEAR) begin
            mem_address    = clr_cnt;
            mem_byteenable = '1;
            mem_chipselect = 1'b1;
            mem_write      = 1'b1;
        end else if (granted) begin
            mem_address    = sel_addr;
            mem_byteenable = sel_be;
            mem_writedata  = sel_wd;
            mem_chipselect = in_range;
            mem_write      = sel_wr && in_range;
        end
    end

    assign mem_clken = 1'b1;

    assign m0_waitrequest = (state == CLEAR) ? req[0] : (req[0] && !grant[0]);
    assign m1_waitrequest = (state == CLEAR) ? req[1] : (req[1] && !grant[1]);

    // Read return: out-of-range reads complete with zero data.
    assign m0_readdatavalid = pend && (pend_owner == 1'b0);
    assign m1_readdatavalid = pend && (pend_owner == 1'b1);
    assign m0_readdata      = (m0_readdatavalid && !pend_oor) ? mem_readdata : '0;
    assign m1_readdata      = (m1_readdatavalid && !pend_oor) ? mem_readdata : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            clr_cnt    <= '0;
            pend       <= 1'b0;
            pend_owner <= 1'b0;
            pend_oor   <= 1'b0;
            init_busy  <= 1'b0;
            init_done  <= 1'b0;
        end else begin
            pend       <= rd_accept;
            pend_owner <= sel;
            pend_oor   <= !in_range;
            init_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (init_start) begin
                        state     <= CLEAR;
                        clr_cnt   <= '0;
                        init_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_cnt == ADDR_W'(NUM_WORDS - 1)) begin
                        state     <= IDLE;
                        clr_cnt   <= '0;
                        init_busy <= 1'b0;
                        init_done <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + ADDR_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Self-checking bench: RAM model, per-cycle behavioural reference, directed and random stimulus.
module tb_onchip_mem_arbiter;

    localparam int NW = 5750;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [12:0] m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic        init_start, init_busy, init_done;
    logic [12:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata, mem_readdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    onchip_mem_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .init_start(init_start), .init_busy(init_busy), .init_done(init_done),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Single-port RAM: address registered at the edge, q valid the following cycle.
    bit [31:0] ram [0:8191];
    bit [31:0] ram_q;
    assign mem_readdata = ram_q;

    always @(posedge clk) begin
        bit [31:0] w;
        if (mem_chipselect) begin
            if (mem_write) begin
                w = ram[mem_address];
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) w[8*b +: 8] = mem_writedata[8*b +: 8];
                ram[mem_address] <= w;
            end else begin
                ram_q <= ram[mem_address];
            end
        end
    end

    // Reference model at transaction level: word array, grant pointer, pending read, clear progress.
    bit        m_valid = 1'b0;
    bit        m_clear, m_last, m_pend, m_owner, m_done;
    int        m_cnt;
    bit [31:0] m_pdata;
    bit [31:0] gold [0:NW-1];

    always @(negedge clk) begin : cmp
        bit        r0, r1, gwr, inr;
        int        g, ga;
        bit [3:0]  gbe;
        bit [31:0] gwd;
        r0 = m0_read | m0_write;
        r1 = m1_read | m1_write;
        g  = -1;
        if (!m_clear && !init_start) begin
            if (r0 && r1)  g = m_last ? 0 : 1;
            else if (r0)   g = 0;
            else if (r1)   g = 1;
        end
        ga  = (g == 1) ? int'(m1_address) : int'(m0_address);
        gbe = (g == 1) ? m1_byteenable : m0_byteenable;
        gwd = (g == 1) ? m1_writedata : m0_writedata;
        gwr = (g == 1) ? m1_write : m0_write;
        inr = ga < NW;
        if (m_valid) begin
            chk1("m0_waitrequest", m0_waitrequest, r0 && g != 0);
            chk1("m1_waitrequest", m1_waitrequest, r1 && g != 1);
            if (m_clear) begin
                chk1("clr_cs", mem_chipselect, 1'b1);
                chk1("clr_we", mem_write, 1'b1);
                chk32("clr_addr", 32'(mem_address), 32'(m_cnt));
                chk32("clr_be", 32'(mem_byteenable), 32'hF);
                chk32("clr_wd", mem_writedata, 32'h0);
            end else if (g < 0) begin
                chk1("idle_cs", mem_chipselect, 1'b0);
                chk1("idle_we", mem_write, 1'b0);
            end else begin
                chk1("mem_cs", mem_chipselect, inr);
                chk1("mem_we", mem_write, gwr && inr);
                if (inr) chk32("mem_addr", 32'(mem_address), 32'(ga));
                if (gwr && inr) begin
                    chk32("mem_be", 32'(mem_byteenable), 32'(gbe));
                    chk32("mem_wd", mem_writedata, gwd);
                end
            end
            chk1("m0_rdv", m0_readdatavalid, m_pend && !m_owner);
            chk1("m1_rdv", m1_readdatavalid, m_pend && m_owner);
            if (m_pend) chk32("readdata", m_owner ? m1_readdata : m0_readdata, m_pdata);
            chk1("init_busy", init_busy, m_clear);
            chk1("init_done", init_done, m_done);
        end
        if (!reset_n) begin
            m_valid = 1'b1; m_clear = 1'b0; m_cnt = 0; m_last = 1'b1;
            m_pend = 1'b0; m_done = 1'b0;
        end else if (m_valid) begin
            m_done = 1'b0;
            m_pend = 1'b0;
            if (m_clear) begin
                gold[m_cnt] = 32'h0;
                if (m_cnt == NW - 1) begin
                    m_clear = 1'b0; m_cnt = 0; m_done = 1'b1;
                end else begin
                    m_cnt++;
                end
            end else if (init_start) begin
                m_clear = 1'b1;
                m_cnt   = 0;
            end else if (g >= 0) begin
                m_last = (g == 1);
                if (gwr) begin
                    if (inr)
                        for (int b = 0; b < 4; b++)
                            if (gbe[b]) gold[ga][8*b +: 8] = gwd[8*b +: 8];
                end else begin
                    m_pend  = 1'b1;
                    m_owner = (g == 1);
                    m_pdata = inr ? gold[ga] : 32'h0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int m, input bit rd, input bit wr, input logic [12:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
        if (m == 0) begin
            m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = wd;
        end else begin
            m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = wd;
        end
    endtask

    function automatic logic [12:0] pick_addr();
        case ($urandom_range(0, 3))
            0:       return 13'($urandom_range(0, 15));
            1:       return 13'($urandom_range(5740, 5763));
            2:       return 13'd100;
            default: return 13'($urandom_range(0, 5749));
        endcase
    endfunction

    initial begin
        int bcnt, dcnt, p0, p1;
        reset_n = 1'b0;
        init_start = 1'b0;
        set_m(0, 0, 0, '0, '0, '0);
        set_m(1, 0, 0, '0, '0, '0);
        repeat (3) step();
        reset_n = 1'b1;
        @(negedge clk);
        chk1("rst_busy", init_busy, 1'b0);
        chk1("rst_done", init_done, 1'b0);
        chk1("rst_rdv0", m0_readdatavalid, 1'b0);
        chk1("rst_rdv1", m1_readdatavalid, 1'b0);
        step();

        // Single-master write then read.
        set_m(0, 0, 1, 13'h10, 4'hF, 32'hDEADBEEF);
        @(negedge clk); chk1("sm_wr_wait", m0_waitrequest, 1'b0); step();
        set_m(0, 1, 0, 13'h10, 4'h0, 32'h0);
        @(negedge clk); chk1("sm_rd_wait", m0_waitrequest, 1'b0); step();
        set_m(0, 0, 0, '0, '0, '0);
        @(negedge clk);
        chk1("sm_rdv", m0_readdatavalid, 1'b1);
        chk32("sm_data", m0_readdata, 32'hDEADBEEF);
        step();

        // Byte-lane merge from master 1.
        set_m(1, 0, 1, 13'h20, 4'hF, 32'hFFFFFFFF); step();
        set_m(1, 0, 1, 13'h20, 4'b0101, 32'h11223344); step();
        set_m(1, 1, 0, 13'h20, 4'h0, 32'h0); step();
        set_m(1, 0, 0, '0, '0, '0);
        @(negedge clk);
        chk1("be_rdv", m1_readdatavalid, 1'b1);
        chk32("be_data", m1_readdata, 32'hFF22FF44);
        step();

        // Contention: both masters hold reads for 6 cycles.
        p0 = 0; p1 = 0;
        set_m(0, 1, 0, 13'h10, 4'h0, 32'h0);
        set_m(1, 1, 0, 13'h20, 4'h0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk1("cont_wait0", m0_waitrequest, (i % 2) == 1);
            chk1("cont_wait1", m1_waitrequest, (i % 2) == 0);
            if (m0_readdatavalid) p0++;
            if (m1_readdatavalid) p1++;
            step();
        end
        set_m(0, 0, 0, '0, '0, '0);
        set_m(1, 0, 0, '0, '0, '0);
        @(negedge clk);
        if (m0_readdatavalid) p0++;
        if (m1_readdatavalid) p1++;
        chk32("cont_pulses0", 32'(p0), 32'd3);
        chk32("cont_pulses1", 32'(p1), 32'd3);
        step();

        // Out-of-range write and read.
        set_m(0, 0, 1, 13'd5750, 4'hF, 32'hAAAA5555);
        @(negedge clk); chk1("oor_wr_cs", mem_chipselect, 1'b0); step();
        set_m(0, 1, 0, 13'd5750, 4'h0, 32'h0);
        @(negedge clk); chk1("oor_rd_cs", mem_chipselect, 1'b0); step();
        set_m(0, 0, 0, '0, '0, '0);
        @(negedge clk);
        chk1("oor_rdv", m0_readdatavalid, 1'b1);
        chk32("oor_data", m0_readdata, 32'h0);
        step();

        // Clear engine.
        set_m(0, 0, 1, 13'd0, 4'hF, 32'h01020304); step();
        set_m(0, 0, 1, 13'd100, 4'hF, 32'h55667788); step();
        set_m(0, 0, 1, 13'd5749, 4'hF, 32'hCAFEF00D); step();
        set_m(0, 0, 0, '0, '0, '0);
        init_start = 1'b1; step();
        init_start = 1'b0;
        set_m(0, 1, 0, 13'd0, 4'h0, 32'h0);
        bcnt = 0; dcnt = 0;
        for (int i = 0; i < 7000; i++) begin
            @(negedge clk);
            if (i < 3) chk1("clr_wait0", m0_waitrequest, 1'b1);
            if (init_busy) bcnt++;
            if (init_done) begin
                dcnt++;
                break;
            end
            step();
            if (i == 2) set_m(0, 0, 0, '0, '0, '0);
        end
        chk32("clr_busy_cycles", 32'(bcnt), 32'd5750);
        chk32("clr_done_pulses", 32'(dcnt), 32'd1);
        step();
        @(negedge clk); chk1("clr_done_single", init_done, 1'b0);
        step();
        foreach (gold[k]) if (k == 0 || k == 100 || k == 5749) begin
            set_m(0, 1, 0, 13'(k), 4'h0, 32'h0); step();
            set_m(0, 0, 0, '0, '0, '0);
            @(negedge clk);
            chk1("clr_rd_rdv", m0_readdatavalid, 1'b1);
            chk32("clr_rd_data", m0_readdata, 32'h0);
            step();
        end

        // Randomized traffic with rare clear requests.
        for (int i = 0; i < 3000; i++) begin
            for (int m = 0; m < 2; m++) begin
                case ($urandom_range(0, 3))
                    0: set_m(m, 1, 0, pick_addr(), 4'($urandom), $urandom);
                    1: set_m(m, 0, 1, pick_addr(), 4'($urandom), $urandom);
                    2: set_m(m, 1, 1, pick_addr(), 4'($urandom), $urandom);
                    default: set_m(m, 0, 0, '0, '0, '0);
                endcase
            end
            init_start = ($urandom_range(0, 1499) == 0);
            step();
        end
        init_start = 1'b0;
        set_m(0, 0, 0, '0, '0, '0);
        set_m(1, 0, 0, '0, '0, '0);
        bcnt = 0;
        while (init_busy && bcnt < 7000) begin
            step();
            bcnt++;
        end
        chk1("rand_clear_ends", init_busy, 1'b0);
        step();

        // Reset in the middle of a clear.
        init_start = 1'b1; step();
        init_start = 1'b0;
        repeat (199) step();
        reset_n = 1'b0; step();
        reset_n = 1'b1;
        @(negedge clk);
        chk1("mid_rst_busy", init_busy, 1'b0);
        chk1("mid_rst_done", init_done, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            @(negedge clk);
            chk1("mid_rst_no_done", init_done, 1'b0);
        end
        step();
        set_m(0, 1, 0, 13'd5, 4'h0, 32'h0);
        set_m(1, 1, 0, 13'd6, 4'h0, 32'h0);
        @(negedge clk);
        chk1("mid_rst_wait0", m0_waitrequest, 1'b0);
        chk1("mid_rst_wait1", m1_waitrequest, 1'b1);
        step();
        set_m(0, 0, 0, '0, '0, '0);
        set_m(1, 0, 0, '0, '0, '0);
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
